// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit drain and the receive path.
package uart_pkg;

  localparam int UART_DATA_BITS         = 8;
  localparam int UART_CLKS_PER_BIT_100M = 868;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_FETCH = 3'd1,
    TX_WAIT  = 3'd2,
    TX_START = 3'd3,
    TX_DATA  = 3'd4,
    TX_STOP  = 3'd5
  } tx_state_t;

endpackage

// File: rtl/uart_tx_drain_if.sv
// Read side of the send FIFO (standard read latency, not first-word-fall-through).
interface uart_tx_drain_if;
  // Pop handshake: Out_snd_rd_en is a one-cycle pulse issued only while
  // In_snd_empty is 0; In_snd_dout holds the popped byte from the next cycle on.
  logic       In_snd_empty;
  logic [7:0] In_snd_dout;
  logic       Out_snd_rd_en;

  modport master (
    input  In_snd_empty,
    input  In_snd_dout,
    output Out_snd_rd_en
  );

  modport slave (
    output In_snd_empty,
    output In_snd_dout,
    input  Out_snd_rd_en
  );
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while running, pulses on the last cycle.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic bit_done
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Deliberately independent of clear: the owner derives clear from bit_done.
  assign bit_done = run && (cnt == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// Drains the send FIFO and shifts each byte out as an 8N1 frame, LSB first.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_100M,
  parameter int CNT_W        = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_enable,
  uart_tx_drain_if.master   snd,
  output logic              Out_tx,
  output logic              Out_busy,
  output logic [CNT_W-1:0]  Out_byte_count,
  output tx_state_t         Out_state
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state, state_next;
  logic [UART_DATA_BITS-1:0] shreg, shreg_next;
  logic [2:0]                bit_idx, bit_idx_next;
  logic                      tx_d, rd_en_d, busy_d, rd_en_q;
  logic                      bit_done, baud_clear, baud_run, start_ok;

  assign start_ok   = In_enable && !snd.In_snd_empty;
  assign baud_run   = (state == TX_START) || (state == TX_DATA) || (state == TX_STOP);
  assign baud_clear = (state_next != state);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .clear    (baud_clear),
    .run      (baud_run),
    .bit_done (bit_done)
  );

  // Outputs are registered from next-cycle values so they line up with state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state          <= TX_IDLE;
      shreg          <= '0;
      bit_idx        <= '0;
      Out_tx         <= 1'b1;
      rd_en_q        <= 1'b0;
      Out_busy       <= 1'b0;
      Out_byte_count <= '0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      bit_idx  <= bit_idx_next;
      Out_tx   <= tx_d;
      rd_en_q  <= rd_en_d;
      Out_busy <= busy_d;
      if (state == TX_STOP && bit_done) begin
        Out_byte_count <= Out_byte_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:  if (start_ok) state_next = TX_FETCH;
      TX_FETCH: state_next = TX_WAIT;
      TX_WAIT:  state_next = TX_START;
      TX_START: if (bit_done) state_next = TX_DATA;
      TX_DATA:  if (bit_done && bit_idx == LAST_BIT) state_next = TX_STOP;
      TX_STOP:  if (bit_done) state_next = start_ok ? TX_FETCH : TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
    if (state == TX_WAIT) begin
      shreg_next = snd.In_snd_dout;
    end
    if (state == TX_DATA && bit_done) begin
      shreg_next   = shreg >> 1;
      bit_idx_next = bit_idx + 1'b1;
    end
    rd_en_d = (state_next == TX_FETCH);
    busy_d  = (state_next != TX_IDLE);
    case (state_next)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shreg_next[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign snd.Out_snd_rd_en = rd_en_q;
  assign Out_state         = state;

endmodule
